// File: rtl/counter_cmd_seq_if.sv
// rtl/counter_cmd_seq_if.sv - command handshake bundle for counter_cmd_seq
interface counter_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_cmd_seq.sv
// rtl/counter_cmd_seq.sv - FIFO-buffered LOAD/UP/DOWN/HOLD sequencer driving an 8-bit up/down counter
module counter_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_,
  counter_cmd_seq_if.slave         cmd,
  output logic                     ld_cnt_,
  output logic                     updn_cnt,
  output logic                     count_enb,
  output logic [7:0]               data_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DOWN = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  logic [1:0]    fifo_op  [DEPTH];
  logic [7:0]    fifo_arg [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;

  state_t     state, state_n;
  logic [7:0] remain, remain_n;
  logic       ld_n, updn_n, enb_n, busy_n, done_n;
  logic [7:0] data_n;
  logic [1:0] head_op;
  logic [7:0] head_arg, head_len;

  assign full          = (level == FULL_LEVEL);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  // The head is taken from IDLE or on the final cycle of the running command.
  assign pop           = (level != '0) && (state == S_IDLE || done);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr]  <= cmd.cmd_op;
      fifo_arg[wr_ptr] <= cmd.cmd_arg;
    end
  end

  assign head_op  = fifo_op[rd_ptr];
  assign head_arg = fifo_arg[rd_ptr];
  assign head_len = (head_arg == 8'd0) ? 8'd1 : head_arg;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= S_IDLE;
      remain    <= 8'd0;
      ld_cnt_   <= 1'b1;
      updn_cnt  <= 1'b0;
      count_enb <= 1'b0;
      data_in   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remain    <= remain_n;
      ld_cnt_   <= ld_n;
      updn_cnt  <= updn_n;
      count_enb <= enb_n;
      data_in   <= data_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    remain_n = remain;
    ld_n     = 1'b1;
    enb_n    = 1'b0;
    updn_n   = updn_cnt;
    data_n   = data_in;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    if (pop) begin
      busy_n = 1'b1;
      case (head_op)
        OP_LOAD: begin
          state_n  = S_LOAD;
          ld_n     = 1'b0;
          data_n   = head_arg;
          remain_n = 8'd0;
          done_n   = 1'b1;
        end
        OP_UP, OP_DOWN: begin
          // N=0 still spends one cycle so done pulses, but with the counter disabled.
          state_n  = S_RUN;
          updn_n   = (head_op == OP_UP);
          enb_n    = (head_arg != 8'd0);
          remain_n = head_len - 8'd1;
          done_n   = (head_len == 8'd1);
        end
        default: begin
          state_n  = S_HOLD;
          remain_n = head_len - 8'd1;
          done_n   = (head_len == 8'd1);
        end
      endcase
    end else if (state != S_IDLE) begin
      if (done) begin
        state_n = S_IDLE;
      end else begin
        busy_n   = 1'b1;
        enb_n    = (state == S_RUN);
        remain_n = remain - 8'd1;
        done_n   = (remain == 8'd1);
      end
    end
  end
endmodule

// File: tb/tb_counter_cmd_seq.sv
// tb/tb_counter_cmd_seq.sv - randomized scoreboard bench for counter_cmd_seq
module tb_counter_cmd_seq;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_UP   = 2'd1;
  localparam logic [1:0] OP_DOWN = 2'd2;
  localparam logic [1:0] OP_HOLD = 2'd3;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  counter_cmd_seq_if cmd ();
  logic          ld_cnt_, updn_cnt, count_enb, busy, done;
  logic [7:0]    data_in;
  logic [LW-1:0] level;

  counter_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .cmd(cmd),
    .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
    .data_in(data_in), .busy(busy), .done(done), .level(level)
  );

  typedef struct {
    int         cyc;
    bit         ld_n, enb, updn, done, chk_updn, chk_data;
    logic [7:0] data;
  } step_t;

  step_t      exp_q[$];
  int         starts_q[$];
  int         last_end = 0;
  int         edge_n = 0;
  logic [7:0] cnt_m = 8'h00;
  logic [7:0] ref_cnt = 8'h00;
  bit         saw_full = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, got, exp);
    end
  endtask

  // Command-level reference: each accepted command occupies max(N,1) cycles (LOAD: 1),
  // starting one edge after it is accepted or right after the previous command ends.
  task automatic model_push(input logic [1:0] op, input logic [7:0] arg, input int e);
    int len;
    int start;
    step_t s;
    len   = (op == OP_LOAD || arg == 8'd0) ? 1 : int'(arg);
    start = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
    for (int i = 0; i < len; i++) begin
      s.cyc      = start + i;
      s.done     = (i == len - 1);
      s.ld_n     = (op != OP_LOAD);
      s.enb      = (op == OP_UP || op == OP_DOWN) && arg != 8'd0;
      s.updn     = (op == OP_UP);
      s.chk_updn = s.enb;
      s.data     = arg;
      s.chk_data = (op == OP_LOAD);
      exp_q.push_back(s);
    end
    starts_q.push_back(start);
    last_end = start + len - 1;
    case (op)
      OP_LOAD: ref_cnt = arg;
      OP_UP:   ref_cnt = ref_cnt + arg;
      OP_DOWN: ref_cnt = ref_cnt - arg;
      default: ref_cnt = ref_cnt;
    endcase
  endtask

  task automatic compare_cycle(input int k);
    step_t s;
    while (starts_q.size() > 0 && starts_q[0] <= k) void'(starts_q.pop_front());
    chk("level", 32'(level), starts_q.size());
    chk("cmd_ready", 32'(cmd.cmd_ready), 32'(starts_q.size() < DEPTH));
    if (!cmd.cmd_ready) saw_full = 1;
    if (exp_q.size() > 0 && exp_q[0].cyc == k) begin
      s = exp_q.pop_front();
      chk("busy", 32'(busy), 1);
      chk("ld_cnt_", 32'(ld_cnt_), 32'(s.ld_n));
      chk("count_enb", 32'(count_enb), 32'(s.enb));
      chk("done", 32'(done), 32'(s.done));
      if (s.chk_updn) chk("updn_cnt", 32'(updn_cnt), 32'(s.updn));
      if (s.chk_data) chk("data_in", 32'(data_in), 32'(s.data));
    end else begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ld_cnt_", 32'(ld_cnt_), 1);
      chk("idle_count_enb", 32'(count_enb), 0);
      chk("idle_done", 32'(done), 0);
    end
  endtask

  // Monitor: the counter plant samples control pins on the edge; the scoreboard compares after it.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst_) begin
        if (!ld_cnt_) cnt_m = data_in;
        else if (count_enb) cnt_m = updn_cnt ? cnt_m + 8'd1 : cnt_m - 8'd1;
        if (cmd.cmd_valid && cmd.cmd_ready) model_push(cmd.cmd_op, cmd.cmd_arg, edge_n);
      end
      #1;
      if (rst_) compare_cycle(edge_n);
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    int n;
    n = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_arg   = arg;
    do begin
      @(posedge clk);
      n++;
    end while (!cmd.cmd_ready && n < 500);
    chk("send_timeout", 32'(n < 500), 1);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cmd.cmd_valid = 1'b0;
    while ((exp_q.size() > 0 || starts_q.size() > 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 1);
    repeat (2) @(posedge clk);
    #2;
    chk("counter_value", 32'(cnt_m), 32'(ref_cnt));
  endtask

  task automatic check_reset();
    chk("rst_ld_cnt_", 32'(ld_cnt_), 1);
    chk("rst_updn_cnt", 32'(updn_cnt), 0);
    chk("rst_count_enb", 32'(count_enb), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_cmd_ready", 32'(cmd.cmd_ready), 1);
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] arg;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 2'd0;
    cmd.cmd_arg   = 8'd0;
    #1 rst_ = 1'b0;
    #2 check_reset();
    repeat (2) @(negedge clk);
    rst_ = 1'b1;

    send(OP_LOAD, 8'hF0); send(OP_UP, 8'd3); drain();
    send(OP_LOAD, 8'h01); send(OP_DOWN, 8'd2); drain();
    send(OP_LOAD, 8'hFE); send(OP_UP, 8'd3); drain();
    send(OP_UP, 8'd0); send(OP_HOLD, 8'd4); drain();

    saw_full = 0;
    send(OP_HOLD, 8'd20);
    send(OP_LOAD, 8'h20); send(OP_UP, 8'd2); send(OP_DOWN, 8'd5);
    send(OP_HOLD, 8'd0); send(OP_UP, 8'd7); send(OP_LOAD, 8'h3C);
    drain();
    chk("backpressure_seen", 32'(saw_full), 1);

    send(OP_LOAD, 8'hA5);
    cmd.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("lat_ld_cnt_", 32'(ld_cnt_), 0);
    @(posedge clk); #1;
    chk("lat_counter", 32'(cnt_m), 32'h A5);
    drain();

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == OP_LOAD) ? 8'($urandom) : 8'($urandom_range(0, 6));
      send(op, arg);
      if ($urandom_range(0, 3) == 0) begin
        cmd.cmd_valid = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    drain();

    send(OP_LOAD, 8'h10); send(OP_UP, 8'd50);
    send(OP_UP, 8'd5); send(OP_DOWN, 8'd5); send(OP_HOLD, 8'd5);
    cmd.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_ = 1'b0;
    #1 check_reset();
    exp_q.delete();
    starts_q.delete();
    last_end = 0;
    ref_cnt  = cnt_m;
    @(negedge clk);
    rst_ = 1'b1;
    send(OP_LOAD, 8'h55);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
